dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Shares the single data-memory port between two requesters: the MEM pipeline stage (port 0) and a secondary master such as fetch refill or the debug loader (port 1). It registers one request at a time onto the memory interface and waits for a variable-latency acknowledge. It returns the read data and a one-cycle acknowledge to the granted requester, and aborts with an error flag if memory fails to respond within a bounded time. It sits between the MEM stage's memory-side outputs and the data memory model.

## Interface
- TIMEOUT, 15: maximum cycles DM_ACK may take after DM_READ/DM_WRITE rises; range 1..2^CNT_W-1.
- CNT_W, 4: width of the timeout counter.

Ports:
- CLK in 1: clock, rising edge.
- RESET in 1: reset, asynchronous, active-low.
- R0_REQ / R1_REQ in 1: access request; held high until the matching ACK.
- R0_WE / R1_WE in 1: 1 = store, 0 = load.
- R0_ADDR / R1_ADDR in 32: byte address, forwarded unmodified.
- R0_WDATA / R1_WDATA in 32: store data.
- R0_SIZE / R1_SIZE in 2: store size; 0 = word, 1 = byte, 2 = half; 3 is treated as word.
- R0_RDATA / R1_RDATA out 32: load data, valid while the matching ACK is high.
- R0_ACK / R1_ACK out 1: one-cycle completion pulse.
- R0_ERR / R1_ERR out 1: high with ACK when the access timed out.
- DM_READ / DM_WRITE out 1: memory strobes; mutually exclusive.
- DM_ADDR out 32, DM_WDATA out 32, DM_SIZE out 2: registered access fields.
- DM_RDATA in 32: memory read data, sampled when DM_ACK is high.
- DM_ACK in 1: memory completion, one cycle.
- BUSY out 1: high in BUSY and RESP states.

## Operation
- States:
  - IDLE: no access in progress.
  - BUSY: strobe driven, waiting for DM_ACK.
  - RESP: one-cycle response to the granted requester.
- IDLE, any Rx_REQ high: choose a winner and latch its WE/ADDR/WDATA/SIZE into the DM_* registers. Set DM_WRITE = WE and DM_READ = !WE. Clear the counter. Record the winner in the `gnt` flag. Go to BUSY.
- BUSY:
  - Counter increments each cycle.
  - DM_ACK high: latch DM_RDATA and clear the error bit. Drop the strobes and go to RESP.
  - Else, counter == TIMEOUT: set the error bit and load the data register with 32'h0. Drop the strobes and go to RESP.
  - DM_ACK and timeout in the same cycle: DM_ACK wins, no error.
- RESP: pulse Rx_ACK for `gnt` and drive Rx_RDATA/Rx_ERR from the latched values. Go to IDLE. The non-granted port's ACK/ERR stay 0.
- Rx_RDATA holds the last latched value outside ACK. Both ports' RDATA show the same register.
- If a requester drops REQ mid-access, the access still completes and ACK still pulses. The requester ignores it.
- DM_ACK while in IDLE or RESP is ignored.
- Arbitration when both REQs are high in IDLE is set by the Configuration section.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - DM_READ, DM_WRITE, DM_ADDR, DM_WDATA, DM_SIZE, all ACK/ERR/RDATA, BUSY, counter and `gnt` all go to 0. The round-robin pointer also goes to 0.
  - Any in-flight access is abandoned with no ACK.

## Timing
- REQ is sampled in cycle N. DM strobe is high from cycle N+1.
- DM_ACK arrives in cycle N+1+L, with L ≥ 0. Rx_ACK is high in cycle N+2+L.
- Minimum request-to-ACK latency: 2 cycles. Minimum back-to-back access issue spacing: L+3 cycles.
- Timeout ACK arrives in cycle N+2+TIMEOUT.
- A requester may deassert REQ in the ACK cycle. If REQ is still high in the cycle after ACK, that is treated as a new request.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin arbitration.
  - A 1-bit pointer names the preferred port; reset value is 0 (port 0 preferred).
  - On contention, the preferred port wins.
  - After each grant, the pointer moves to the other port.
  - An uncontended request is granted regardless of the pointer.
- DMEM_ARB_RR_EN undefined: fixed priority. Port 0 always wins contention, and port 1 may starve. The pointer logic is absent.

## Test plan
- Single load, port 0: ADDR 32'h100, WE 0, memory responds with L = 2 and DM_RDATA 32'hDEADBEEF. DM_READ is high cycles N+1..N+3, DM_ADDR = 32'h100, and R0_ACK is high at N+4 with R0_RDATA = 32'hDEADBEEF and R0_ERR = 0.
- Byte store, port 1: WDATA 32'h000000AB, SIZE 1, L = 0. DM_WRITE = 1, DM_SIZE = 1, DM_WDATA = 32'hAB, and R1_ACK is high at N+2.
- Contention: R0 and R1 held high continuously, L = 0.
  - With DMEM_ARB_RR_EN, grants go 0,1,0,1.
  - Without it, grants go 0,0,0 and R1_ACK never rises.
- Timeout: port 0 load with DM_ACK never asserted, TIMEOUT = 15. R0_ACK and R0_ERR are high at N+17 with R0_RDATA = 0, and BUSY falls the next cycle.
- Reset mid-access: RESET low during BUSY. DM_READ drops asynchronously, no ACK is issued, and after release a new port 1 request completes normally.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//
// Purpose:
//   Shares the single data-memory port between two requesters: port 0 (MEM
//   pipeline stage) and port 1 (secondary master such as refill or debug
//   loader). One access at a time is registered onto the DM_* interface. The
//   arbiter then waits for a variable-latency DM_ACK and returns a one-cycle
//   ACK with the read data to the granted port. If memory does not answer
//   within TIMEOUT cycles, the access is aborted with ERR set and zero data.
//
// Configuration:
//   DMEM_ARB_RR_EN  defined   -> round-robin arbitration on contention
//                   undefined -> fixed priority (port 0 always wins)
//
// Parameters:
//   TIMEOUT  maximum DM_ACK wait in cycles (1 .. 2**CNT_W-1)
//   CNT_W    timeout counter width
//
// Ports:
//   CLK, RESET                      clock (rising edge), async active-low reset
//   Rx_REQ/WE/ADDR/WDATA/SIZE       requester side inputs, x = 0, 1
//   Rx_RDATA/ACK/ERR                requester side responses
//   DM_READ/WRITE/ADDR/WDATA/SIZE   registered memory request fields
//   DM_RDATA, DM_ACK                memory response
//   BUSY                            high while an access is in flight or
//                                   being answered
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 4
) (
    input  logic        CLK,
    input  logic        RESET,

    input  logic        R0_REQ,
    input  logic        R0_WE,
    input  logic [31:0] R0_ADDR,
    input  logic [31:0] R0_WDATA,
    input  logic [1:0]  R0_SIZE,
    output logic [31:0] R0_RDATA,
    output logic        R0_ACK,
    output logic        R0_ERR,

    input  logic        R1_REQ,
    input  logic        R1_WE,
    input  logic [31:0] R1_ADDR,
    input  logic [31:0] R1_WDATA,
    input  logic [1:0]  R1_SIZE,
    output logic [31:0] R1_RDATA,
    output logic        R1_ACK,
    output logic        R1_ERR,

    output logic        DM_READ,
    output logic        DM_WRITE,
    output logic [31:0] DM_ADDR,
    output logic [31:0] DM_WDATA,
    output logic [1:0]  DM_SIZE,
    input  logic [31:0] DM_RDATA,
    input  logic        DM_ACK,

    output logic        BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_q,    state_d;
    logic               gnt_q,      gnt_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic               dm_read_q,  dm_read_d;
    logic               dm_write_q, dm_write_d;
    logic [31:0]        dm_addr_q,  dm_addr_d;
    logic [31:0]        dm_wdata_q, dm_wdata_d;
    logic [1:0]         dm_size_q,  dm_size_d;
    logic [31:0]        rdata_q,    rdata_d;
    logic               r0_ack_q,   r0_ack_d;
    logic               r1_ack_q,   r1_ack_d;
    logic               r0_err_q,   r0_err_d;
    logic               r1_err_q,   r1_err_d;
    logic               busy_q,     busy_d;
`ifdef DMEM_ARB_RR_EN
    logic               rr_q,       rr_d;
`endif

    logic               win_s;
    logic               any_req_s;

    assign any_req_s = R0_REQ | R1_REQ;

    // Arbitration: pick the port to grant when at least one request is present.
    always_comb begin
`ifdef DMEM_ARB_RR_EN
        // rr_q names the preferred port; it only matters under contention.
        if (R0_REQ && R1_REQ) begin
            win_s = rr_q;
        end else if (R0_REQ) begin
            win_s = 1'b0;
        end else begin
            win_s = 1'b1;
        end
`else
        if (R0_REQ) begin
            win_s = 1'b0;
        end else begin
            win_s = 1'b1;
        end
`endif
    end

    // Next-state and next-output computation for the access sequencer.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        cnt_d      = cnt_q;
        dm_read_d  = dm_read_q;
        dm_write_d = dm_write_q;
        dm_addr_d  = dm_addr_q;
        dm_wdata_d = dm_wdata_q;
        dm_size_d  = dm_size_q;
        rdata_d    = rdata_q;
        busy_d     = busy_q;
        // ACK/ERR are single-cycle pulses: low unless set below.
        r0_ack_d   = 1'b0;
        r1_ack_d   = 1'b0;
        r0_err_d   = 1'b0;
        r1_err_d   = 1'b0;
`ifdef DMEM_ARB_RR_EN
        rr_d       = rr_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    gnt_d      = win_s;
                    dm_write_d = win_s ? R1_WE    : R0_WE;
                    dm_read_d  = win_s ? ~R1_WE   : ~R0_WE;
                    dm_addr_d  = win_s ? R1_ADDR  : R0_ADDR;
                    dm_wdata_d = win_s ? R1_WDATA : R0_WDATA;
                    dm_size_d  = win_s ? R1_SIZE  : R0_SIZE;
                    cnt_d      = {CNT_W{1'b0}};
                    busy_d     = 1'b1;
                    state_d    = ST_BUSY;
`ifdef DMEM_ARB_RR_EN
                    rr_d       = ~win_s;
`endif
                end else begin
                    busy_d     = 1'b0;
                    state_d    = ST_IDLE;
                end
            end

            ST_BUSY: begin
                cnt_d = cnt_q + CNT_W'(1'b1);
                // DM_ACK is checked first so an ACK on the timeout cycle wins.
                if (DM_ACK) begin
                    rdata_d    = DM_RDATA;
                    dm_read_d  = 1'b0;
                    dm_write_d = 1'b0;
                    r0_ack_d   = ~gnt_q;
                    r1_ack_d   = gnt_q;
                    state_d    = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    rdata_d    = 32'h0000_0000;
                    dm_read_d  = 1'b0;
                    dm_write_d = 1'b0;
                    r0_ack_d   = ~gnt_q;
                    r1_ack_d   = gnt_q;
                    r0_err_d   = ~gnt_q;
                    r1_err_d   = gnt_q;
                    state_d    = ST_RESP;
                end else begin
                    state_d    = ST_BUSY;
                end
            end

            ST_RESP: begin
                // ACK pulse is on the outputs this cycle; REQ is not sampled here.
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                dm_read_d  = 1'b0;
                dm_write_d = 1'b0;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // State and output registers; asynchronous reset abandons any access.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
            dm_read_q  <= 1'b0;
            dm_write_q <= 1'b0;
            dm_addr_q  <= 32'h0000_0000;
            dm_wdata_q <= 32'h0000_0000;
            dm_size_q  <= 2'd0;
            rdata_q    <= 32'h0000_0000;
            r0_ack_q   <= 1'b0;
            r1_ack_q   <= 1'b0;
            r0_err_q   <= 1'b0;
            r1_err_q   <= 1'b0;
            busy_q     <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            rr_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            cnt_q      <= cnt_d;
            dm_read_q  <= dm_read_d;
            dm_write_q <= dm_write_d;
            dm_addr_q  <= dm_addr_d;
            dm_wdata_q <= dm_wdata_d;
            dm_size_q  <= dm_size_d;
            rdata_q    <= rdata_d;
            r0_ack_q   <= r0_ack_d;
            r1_ack_q   <= r1_ack_d;
            r0_err_q   <= r0_err_d;
            r1_err_q   <= r1_err_d;
            busy_q     <= busy_d;
`ifdef DMEM_ARB_RR_EN
            rr_q       <= rr_d;
`endif
        end
    end

    assign DM_READ  = dm_read_q;
    assign DM_WRITE = dm_write_q;
    assign DM_ADDR  = dm_addr_q;
    assign DM_WDATA = dm_wdata_q;
    assign DM_SIZE  = dm_size_q;
    // Both ports see the same latched data register.
    assign R0_RDATA = rdata_q;
    assign R1_RDATA = rdata_q;
    assign R0_ACK   = r0_ack_q;
    assign R1_ACK   = r1_ack_q;
    assign R0_ERR   = r0_err_q;
    assign R1_ERR   = r1_err_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_port_arbiter
//
// Self-checking bench for dmem_port_arbiter. Each access is described as a
// transaction: the requesting ports, their fields, and the memory latency.
// A transaction-level model predicts the winner, the DM_* fields, the ACK
// cycle, ERR, and the returned data. Directed cases come first, then a
// randomized run. Honours DMEM_ARB_RR_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_dmem_port_arbiter;

    localparam int TO = 15;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        R0_REQ, R0_WE, R1_REQ, R1_WE;
    logic [31:0] R0_ADDR, R0_WDATA, R1_ADDR, R1_WDATA;
    logic [1:0]  R0_SIZE, R1_SIZE;
    logic [31:0] R0_RDATA, R1_RDATA;
    logic        R0_ACK, R0_ERR, R1_ACK, R1_ERR;
    logic        DM_READ, DM_WRITE;
    logic [31:0] DM_ADDR, DM_WDATA, DM_RDATA;
    logic [1:0]  DM_SIZE;
    logic        DM_ACK;
    logic        BUSY;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef DMEM_ARB_RR_EN
    bit pref_port;
`endif

    dmem_port_arbiter #(.TIMEOUT(TO), .CNT_W(4)) dut (
        .CLK(CLK), .RESET(RESET),
        .R0_REQ(R0_REQ), .R0_WE(R0_WE), .R0_ADDR(R0_ADDR), .R0_WDATA(R0_WDATA),
        .R0_SIZE(R0_SIZE), .R0_RDATA(R0_RDATA), .R0_ACK(R0_ACK), .R0_ERR(R0_ERR),
        .R1_REQ(R1_REQ), .R1_WE(R1_WE), .R1_ADDR(R1_ADDR), .R1_WDATA(R1_WDATA),
        .R1_SIZE(R1_SIZE), .R1_RDATA(R1_RDATA), .R1_ACK(R1_ACK), .R1_ERR(R1_ERR),
        .DM_READ(DM_READ), .DM_WRITE(DM_WRITE), .DM_ADDR(DM_ADDR),
        .DM_WDATA(DM_WDATA), .DM_SIZE(DM_SIZE), .DM_RDATA(DM_RDATA),
        .DM_ACK(DM_ACK), .BUSY(BUSY)
    );

    // Free-running clock, 10 time-unit period.
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One access from IDLE. Returns in the cycle after the ACK (DUT in IDLE).
    task automatic run_txn(input bit q0, input bit q1, input bit we0, input bit we1,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic [1:0] s0, input logic [1:0] s1,
                           input int lat, input logic [31:0] mem_data);
        bit          w;
        bit          timed_out;
        bit          exp_we;
        int          wait_cyc;
        logic [31:0] exp_rdata;

        // Reference model: who wins, when ACK appears, what it carries.
`ifdef DMEM_ARB_RR_EN
        if (q0 && q1) w = pref_port;
        else          w = q1 && !q0;
        pref_port = !w;
`else
        w = !q0;
`endif
        timed_out = (lat > TO);
        wait_cyc  = timed_out ? TO : lat;
        exp_rdata = timed_out ? 32'h0 : mem_data;
        exp_we    = w ? we1 : we0;

        // Cycle N: present requests.
        R0_REQ = q0; R0_WE = we0; R0_ADDR = a0; R0_WDATA = d0; R0_SIZE = s0;
        R1_REQ = q1; R1_WE = we1; R1_ADDR = a1; R1_WDATA = d1; R1_SIZE = s1;
        tick();

        // Cycle N+1: registered request fields.
        check_eq("dm_write", DM_WRITE, exp_we);
        check_eq("dm_read",  DM_READ,  !exp_we);
        check_eq("dm_addr",  DM_ADDR,  w ? a1 : a0);
        check_eq("dm_wdata", DM_WDATA, w ? d1 : d0);
        check_eq("dm_size",  DM_SIZE,  w ? s1 : s0);
        check_eq("busy_on",  BUSY,     1'b1);

        // Cycles N+1 .. N+1+wait_cyc: strobe held, no ACK yet.
        for (int k = 0; k <= wait_cyc; k++) begin
            check_eq("no_early_ack", {R0_ACK, R1_ACK}, 2'b00);
            check_eq("strobe_held", DM_READ | DM_WRITE, 1'b1);
            if (k == lat) begin
                DM_ACK   = 1'b1;
                DM_RDATA = mem_data;
            end
            tick();
            DM_ACK   = 1'b0;
            DM_RDATA = $urandom;
        end

        // Cycle N+2+wait_cyc: response.
        check_eq("r0_ack",   R0_ACK,   !w);
        check_eq("r1_ack",   R1_ACK,   w);
        check_eq("r0_err",   R0_ERR,   !w && timed_out);
        check_eq("r1_err",   R1_ERR,   w && timed_out);
        check_eq("r0_rdata", R0_RDATA, exp_rdata);
        check_eq("r1_rdata", R1_RDATA, exp_rdata);
        check_eq("strobe_off", {DM_READ, DM_WRITE}, 2'b00);
        check_eq("busy_resp", BUSY, 1'b1);

        // A stray DM_ACK during the response cycle must be ignored.
        DM_ACK   = 1'($urandom_range(0, 1));
        DM_RDATA = $urandom;
        R0_REQ = 1'b0;
        R1_REQ = 1'b0;
        tick();
        DM_ACK = 1'b0;

        check_eq("ack_pulse", {R0_ACK, R1_ACK, R0_ERR, R1_ERR}, 4'b0000);
        check_eq("busy_off",  BUSY,     1'b0);
        check_eq("rdata_hold", R0_RDATA, exp_rdata);
    endtask

    initial begin
        RESET = 1'b0;
        R0_REQ = 1'b0; R0_WE = 1'b0; R0_ADDR = 32'h0; R0_WDATA = 32'h0; R0_SIZE = 2'd0;
        R1_REQ = 1'b0; R1_WE = 1'b0; R1_ADDR = 32'h0; R1_WDATA = 32'h0; R1_SIZE = 2'd0;
        DM_ACK = 1'b0; DM_RDATA = 32'h0;
`ifdef DMEM_ARB_RR_EN
        pref_port = 1'b0;
`endif
        tick();
        tick();

        // Reset values.
        check_eq("rst_strobes", {DM_READ, DM_WRITE}, 2'b00);
        check_eq("rst_addr",    DM_ADDR,  32'h0);
        check_eq("rst_wdata",   DM_WDATA, 32'h0);
        check_eq("rst_acks",    {R0_ACK, R1_ACK, R0_ERR, R1_ERR}, 4'b0000);
        check_eq("rst_rdata",   R0_RDATA, 32'h0);
        check_eq("rst_busy",    BUSY,     1'b0);

        RESET = 1'b1;
        tick();

        // Single load on port 0, latency 2.
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 32'h0,
                2'd0, 2'd0, 2, 32'hDEAD_BEEF);
        // Byte store on port 1, latency 0.
        run_txn(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h204, 32'h0, 32'h0000_00AB,
                2'd0, 2'd1, 0, 32'h1234_5678);
        // Contention, back-to-back, latency 0.
        for (int i = 0; i < 4; i++) begin
            run_txn(1'b1, 1'b1, 1'b0, 1'b1, 32'h300 + i, 32'h400 + i,
                    32'h5000 + i, 32'h6000 + i, 2'd0, 2'd2, 0, 32'hC0DE_0000 + i);
        end
        // Timeout on port 0 load.
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h800, 32'h0, 32'h0, 32'h0,
                2'd0, 2'd0, TO + 10, 32'hFFFF_FFFF);
        // DM_ACK exactly on the timeout cycle: no error.
        run_txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h900, 32'h0, 32'h0,
                2'd0, 2'd0, TO, 32'hA5A5_5A5A);

        // Reset in the middle of a load.
        R0_REQ = 1'b1; R0_WE = 1'b0; R0_ADDR = 32'hA00;
        tick();
        tick();
        check_eq("pre_rst_read", DM_READ, 1'b1);
        #2;
        RESET  = 1'b0;
        R0_REQ = 1'b0;
        #1;
        check_eq("async_rst_read", DM_READ, 1'b0);
        check_eq("async_rst_busy", BUSY,    1'b0);
        DM_ACK   = 1'b1;
        DM_RDATA = 32'hBAD0_BAD0;
        tick();
        DM_ACK = 1'b0;
        tick();
        check_eq("rst_no_ack",   {R0_ACK, R1_ACK}, 2'b00);
        check_eq("rst_rdata_clr", R0_RDATA, 32'h0);
        RESET = 1'b1;
`ifdef DMEM_ARB_RR_EN
        pref_port = 1'b0;
`endif
        tick();
        run_txn(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'hB00, 32'h0, 32'h0,
                2'd0, 2'd0, 1, 32'h0BAD_F00D);
        run_txn(1'b1, 1'b1, 1'b1, 1'b1, 32'hC00, 32'hC04, 32'h11, 32'h22,
                2'd2, 2'd1, 3, 32'h3333_4444);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            int          m;
            int          lat;
            m   = $urandom_range(1, 3);
            lat = ($urandom_range(0, 9) == 0) ? TO + 1 + $urandom_range(0, 2)
                                              : $urandom_range(0, 6);
            run_txn(m[0], m[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom, $urandom, $urandom, $urandom,
                    2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)),
                    lat, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
